// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // PS/2 uses odd parity across the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines, debounces ps2_clk and emits a one-cycle
// strobe on each filtered falling edge.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic strobe
);

    localparam logic [7:0] RUN_LAST = 8'(FILTER_CYCLES - 1);

    logic       clk_p0, clk_p1;
    logic       data_p0, data_p1;
    logic       clk_filt;
    logic [7:0] run_cnt;

    assign data_sync = data_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_p0   <= 1'b1;
            clk_p1   <= 1'b1;
            data_p0  <= 1'b1;
            data_p1  <= 1'b1;
            clk_filt <= 1'b1;
            run_cnt  <= 8'd0;
            strobe   <= 1'b0;
        end else begin
            // two-flop synchronizer stage
            clk_p0  <= ps2_clk;
            clk_p1  <= clk_p0;
            data_p0 <= ps2_data;
            data_p1 <= data_p0;
            // filter stage: flip only after a full run of disagreeing samples
            strobe  <= 1'b0;
            if (clk_p1 != clk_filt) begin
                if (run_cnt == RUN_LAST) begin
                    clk_filt <= clk_p1;
                    run_cnt  <= 8'd0;
                    strobe   <= clk_filt;
                end else begin
                    run_cnt <= run_cnt + 8'd1;
                end
            end else begin
                run_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frame FSM, inter-bit watchdog and arrow-key decoder.
// Define PS2_PARITY_CHECK_EN to reject frames with a parity mismatch.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    logic            strobe;
    logic            data_bit;
    frame_state_t    state, state_nxt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic [WD_W-1:0] wd_cnt;
    logic            shift_en;
    logic            frame_ok;
    logic            frame_bad;
    logic            timeout;
    logic            parity_good;
    logic            ext_pending;
    logic            brk_pending;

    ps2_line_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_line_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_sync(data_bit),
        .strobe   (strobe)
    );

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;

    always_ff @(posedge clk) begin
        if (strobe && state == PARITY)
            parity_bit <= data_bit;
    end

    assign parity_good = odd_parity_ok(shift_reg, parity_bit);
`else
    assign parity_good = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        // a strobe in the expiry cycle restarts the count instead of aborting
        timeout   = (state != IDLE) && !strobe && (wd_cnt == WD_LAST);
        case (state)
            IDLE: begin
                if (strobe && !data_bit)
                    state_nxt = DATA;
            end
            DATA: begin
                if (strobe) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (strobe)
                    state_nxt = STOP;
            end
            STOP: begin
                if (strobe) begin
                    state_nxt = IDLE;
                    if (data_bit && parity_good)
                        frame_ok = 1'b1;
                    else
                        frame_bad = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (timeout)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (shift_en)
            shift_reg <= {data_bit, shift_reg[7:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            wd_cnt  <= '0;
        end else begin
            if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;
            else if (state != DATA)
                bit_cnt <= 3'd0;
            if (strobe)
                wd_cnt <= '0;
            else if (state != IDLE && wd_cnt != WD_MAX)
                wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // decode stage: byte, pulses and key levels all update together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_error    <= 1'b0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            move_up     <= 1'b0;
            move_down   <= 1'b0;
            move_left   <= 1'b0;
            move_right  <= 1'b0;
        end else begin
            rx_valid <= frame_ok;
            rx_error <= frame_bad | timeout;
            if (frame_ok) begin
                rx_byte <= shift_reg;
                if (shift_reg == SC_EXT) begin
                    ext_pending <= 1'b1;
                end else if (shift_reg == SC_BRK) begin
                    brk_pending <= 1'b1;
                end else begin
                    if (ext_pending) begin
                        case (shift_reg)
                            SC_UP:    move_up    <= !brk_pending;
                            SC_DOWN:  move_down  <= !brk_pending;
                            SC_LEFT:  move_left  <= !brk_pending;
                            SC_RIGHT: move_right <= !brk_pending;
                            default:  ;
                        endcase
                    end
                    ext_pending <= 1'b0;
                    brk_pending <= 1'b0;
                end
            end else if (frame_bad || timeout) begin
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and
// compares outputs against hand-computed values.
module tb_ps2_key_decoder;

    localparam int FILT = 8;
    localparam int TMO  = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_error;
    logic       move_up, move_down, move_left, move_right;
    logic [3:0] moves;

    int n_cmp = 0;
    int n_bad = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    assign moves = {move_up, move_down, move_left, move_right};

    ps2_key_decoder #(
        .FILTER_CYCLES (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .move_up   (move_up),
        .move_down (move_down),
        .move_left (move_left),
        .move_right(move_right)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) vld_cnt++;
        if (rx_error) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d ^ bad_par);
        send_bit(!bad_stop);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int         v0, e0, lat;
        bit         seen;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("rst_byte", rx_byte, 32'h00);
        check("rst_pulses", {rx_valid, rx_error}, 32'h0);
        check("rst_moves", moves, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        key(8'hE0); key(8'h75);
        check("pre_up", moves, 32'b1000);
        check("pre_byte", rx_byte, 32'h75);

        // reset asynchronously after start bit plus four data bits
        d = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        #3 reset = 1'b1;
        #1;
        check("midrst_byte", rx_byte, 32'h00);
        check("midrst_moves", moves, 32'h0);
        check("midrst_pulses", {rx_valid, rx_error}, 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // clean 0x1C with stop-edge to rx_valid latency measured
        v0 = vld_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        lat = 0; seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (rx_valid) seen = 1;
        end
        check("lat_1c", lat, FILT + 3);
        check("byte_1c", rx_byte, 32'h1C);
        @(negedge clk);
        check("vld_width", rx_valid, 32'h0);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        check("vld_1c", vld_cnt - v0, 32'd1);

        key(8'hE0);
        check("up_after_e0", moves, 32'b0000);
        key(8'h75);
        check("up_make", moves, 32'b1000);
        key(8'hE0); key(8'hF0);
        check("up_mid_break", moves, 32'b1000);
        key(8'h75);
        check("up_break", moves, 32'b0000);

        key(8'hE0); key(8'h6B); key(8'hE0); key(8'h74);
        check("left_right", moves, 32'b0011);
        key(8'hE0); key(8'hF0); key(8'h6B);
        check("right_only", moves, 32'b0001);

        v0 = vld_cnt; e0 = err_cnt;
        send_frame(8'h33, 1'b0, 1'b1);
        check("stop0_err", err_cnt - e0, 32'd1);
        check("stop0_vld", vld_cnt - v0, 32'd0);

        v0 = vld_cnt;
        key(8'h75);
        check("keypad_vld", vld_cnt - v0, 32'd1);
        check("keypad_byte", rx_byte, 32'h75);
        check("keypad_moves", moves, 32'b0001);

        key(8'hE0);
        send_frame(8'h11, 1'b0, 1'b1);
        key(8'h72);
        check("err_clears_ext", moves, 32'b0001);

        v0 = vld_cnt; e0 = err_cnt;
        key(8'h29);
        send_frame(8'h75, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err", err_cnt - e0, 32'd1);
        check("par_vld", vld_cnt - v0, 32'd1);
        check("par_byte", rx_byte, 32'h29);
`else
        check("par_err", err_cnt - e0, 32'd0);
        check("par_vld", vld_cnt - v0, 32'd2);
        check("par_byte", rx_byte, 32'h75);
`endif

        // watchdog: clock stops low after the fifth bit
        v0 = vld_cnt; e0 = err_cnt;
        d = 8'h0F;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        @(negedge clk);
        ps2_data = d[3];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        lat = 0; seen = 0;
        for (int k = 0; k < FILT + TMO + 50 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (rx_error) seen = 1;
        end
        check("tmo_lat", lat, FILT + 3 + TMO);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        check("tmo_err", err_cnt - e0, 32'd1);
        key(8'h5A);
        check("tmo_next_byte", rx_byte, 32'h5A);
        check("tmo_next_vld", vld_cnt - v0, 32'd1);

        // three-cycle glitches with data low must not start a frame
        v0 = vld_cnt; e0 = err_cnt;
        @(negedge clk);
        ps2_data = 1'b0;
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        check("glitch_quiet", (vld_cnt - v0) + (err_cnt - e0), 32'd0);
        key(8'h29);
        check("glitch_byte", rx_byte, 32'h29);
        check("glitch_vld", vld_cnt - v0, 32'd1);
        check("glitch_err", err_cnt - e0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
